div_unit: RTL and testbench

Parametrised multi-cycle integer divider for the CPU54 datapath, serving the DIV and DIVU instructions. It computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock, in signed or unsigned mode, selected per operation. It reports divide-by-zero and signed overflow explicitly. It supports a synchronous flush so the pipeline can abandon an in-flight division on an exception.

---
 rtl/div_unit.sv | 173 +++++++++++++++++
 tb/tb_div_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// One quotient bit per clock; signed or unsigned per operation.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             sgn_q, sgn_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             dz_p_q, dz_p_d;
    logic             ov_p_q, ov_p_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic             overflow_q, overflow_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH+1:0] shl, diff;
    logic [WIDTH-1:0] q_fix, r_fix;

    always_comb begin
        a_neg = sign_mode & dividend[WIDTH-1];
        b_neg = sign_mode & divisor[WIDTH-1];
        mag_a = a_neg ? (~dividend + 1'b1) : dividend;
        mag_b = b_neg ? (~divisor + 1'b1) : divisor;
        // shift next dividend bit into the partial remainder, then trial subtract
        shl   = {rem_q, quo_q[WIDTH-1]};
        diff  = shl - {2'b00, dsr_q};
        q_fix = (sgn_q & (neg_a_q ^ neg_b_q)) ? (~quo_q + 1'b1) : quo_q;
        r_fix = (sgn_q & neg_a_q) ? (~rem_q[WIDTH-1:0] + 1'b1)
                                  : rem_q[WIDTH-1:0];
        if (dz_p_q) q_fix = '1;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        sgn_d       = sgn_q;
        neg_a_d     = neg_a_q;
        neg_b_d     = neg_b_q;
        dz_p_d      = dz_p_q;
        ov_p_d      = ov_p_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    sgn_d   = sign_mode;
                    neg_a_d = a_neg;
                    neg_b_d = b_neg;
                    quo_d   = mag_a;
                    dsr_d   = mag_b;
                    rem_d   = '0;
                    cnt_d   = '0;
                    dz_p_d  = (divisor == '0);
                    ov_p_d  = sign_mode
                            && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                            && (&divisor);
                    busy_d  = 1'b1;
                    state_d = ITER;
                end
            end
            ITER: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (!diff[WIDTH+1]) begin
                        rem_d = diff[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shl[WIDTH:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (!flush) begin
                    quotient_d  = q_fix;
                    remainder_d = r_fix;
                    div_zero_d  = dz_p_q;
                    overflow_d  = ov_p_q;
                    done_d      = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            sgn_q       <= 1'b0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            dz_p_q      <= 1'b0;
            ov_p_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            sgn_q       <= sgn_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            dz_p_q      <= dz_p_d;
            ov_p_q      <= ov_p_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit.
// Directed checks at WIDTH=32, random checks at WIDTH=8.
module tb_div_unit;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_n;

    logic        s32_start, s32_sm, s32_flush;
    logic [31:0] s32_a, s32_b, q32, r32;
    logic        busy32, done32, dz32, ov32;

    logic        s8_start, s8_sm, s8_flush;
    logic [7:0]  s8_a, s8_b, q8, r8;
    logic        busy8, done8, dz8, ov8;

    div_unit #(.WIDTH(32)) u32 (
        .clock(clock), .reset_n(reset_n), .start(s32_start),
        .sign_mode(s32_sm), .dividend(s32_a), .divisor(s32_b),
        .flush(s32_flush), .quotient(q32), .remainder(r32),
        .busy(busy32), .done(done32), .div_zero(dz32), .overflow(ov32)
    );

    div_unit #(.WIDTH(8)) u8 (
        .clock(clock), .reset_n(reset_n), .start(s8_start),
        .sign_mode(s8_sm), .dividend(s8_a), .divisor(s8_b),
        .flush(s8_flush), .quotient(q8), .remainder(r8),
        .busy(busy8), .done(done8), .div_zero(dz8), .overflow(ov8)
    );

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        bit          dz;
        bit          ov;
        int          due;
    } exp_t;

    exp_t sb32[$];
    exp_t sb8[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic [31:0] last_q32 = '0;
    logic [31:0] last_r32 = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin : mon32
        exp_t e;
        if (reset_n && done32) begin
            if (sb32.size() == 0) begin
                check("sb32_extra_done", 1, 0);
            end else begin
                e = sb32.pop_front();
                check("q32", q32, e.q);
                check("r32", r32, e.r);
                check("dz32", dz32, e.dz);
                check("ov32", ov32, e.ov);
                check("lat32", cyc, e.due);
                check("busy32_at_done", busy32, 0);
                last_q32 = e.q[31:0];
                last_r32 = e.r[31:0];
            end
        end
    end

    always @(negedge clock) begin : mon8
        exp_t e;
        if (reset_n && done8) begin
            if (sb8.size() == 0) begin
                check("sb8_extra_done", 1, 0);
            end else begin
                e = sb8.pop_front();
                check("q8", q8, e.q);
                check("r8", r8, e.r);
                check("dz8", dz8, e.dz);
                check("ov8", ov8, e.ov);
                check("lat8", cyc, e.due);
            end
        end
    end

    task automatic wait_idle32();
        int n = 0;
        while (busy32 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (busy32) check("idle32_timeout", 1, 0);
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (busy8 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (busy8) check("idle8_timeout", 1, 0);
    endtask

    task automatic issue32(bit sm, logic [31:0] a, logic [31:0] b,
                           logic [31:0] q, logic [31:0] r, bit dz, bit ov);
        wait_idle32();
        s32_start = 1'b1;
        s32_sm    = sm;
        s32_a     = a;
        s32_b     = b;
        if (!busy32) sb32.push_back('{64'(q), 64'(r), dz, ov, cyc + 34});
        @(negedge clock);
        s32_start = 1'b0;
    endtask

    task automatic issue8(bit sm, logic [7:0] a, logic [7:0] b,
                          logic [7:0] q, logic [7:0] r, bit dz, bit ov);
        wait_idle8();
        s8_start = 1'b1;
        s8_sm    = sm;
        s8_a     = a;
        s8_b     = b;
        if (!busy8) sb8.push_back('{64'(q), 64'(r), dz, ov, cyc + 10});
        @(negedge clock);
        s8_start = 1'b0;
    endtask

    function automatic void model8(input bit sm, input logic [7:0] a,
                                   input logic [7:0] b,
                                   output logic [7:0] q, output logic [7:0] r,
                                   output bit dz, output bit ov);
        int sa, sbv;
        dz = (b == 8'd0);
        ov = 1'b0;
        if (b == 8'd0) begin
            q = 8'hFF;
            r = a;
        end else if (sm) begin
            sa  = $signed(a);
            sbv = $signed(b);
            q   = 8'(sa / sbv);
            r   = 8'(sa % sbv);
            ov  = (sa == -128) && (sbv == -1);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic [7:0] pick();
        logic [7:0] c [5];
        c = '{8'h00, 8'h80, 8'hFF, 8'h01, 8'h7F};
        if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
        return 8'($urandom);
    endfunction

    initial begin
        logic [7:0] ra, rb, rq, rr;
        bit         rdz, rov, rsm;
        reset_n   = 1'b0;
        s32_start = 0; s32_sm = 0; s32_flush = 0; s32_a = 0; s32_b = 0;
        s8_start  = 0; s8_sm = 0;  s8_flush = 0;  s8_a = 0;  s8_b = 0;
        #12;
        check("rst_q32", q32, 0);
        check("rst_r32", r32, 0);
        check("rst_busy32", busy32, 0);
        check("rst_done32", done32, 0);
        check("rst_flags32", {dz32, ov32}, 0);
        check("rst_q8", {q8, r8, busy8, done8}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        issue32(1, 32'd7, 32'd2, 32'd3, 32'd1, 0, 0);
        issue32(1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0);
        issue32(1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0, 0);
        issue32(0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 0, 0);
        issue32(1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0);
        issue32(0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1, 0);
        issue32(1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1, 0);
        issue32(1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1, 0);
        issue32(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0, 1);
        issue32(0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0, 0);

        // start while busy must be ignored
        issue32(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0);
        repeat (4) @(negedge clock);
        s32_start = 1'b1;
        s32_a     = 32'd999;
        s32_b     = 32'd3;
        @(negedge clock);
        s32_start = 1'b0;
        wait_idle32();
        @(negedge clock);

        // start together with flush in idle: dropped
        s32_start = 1'b1;
        s32_flush = 1'b1;
        @(negedge clock);
        s32_start = 1'b0;
        s32_flush = 1'b0;
        check("flush_idle_busy", busy32, 0);
        @(negedge clock);
        check("flush_idle_busy2", busy32, 0);

        // flush mid operation
        issue32(1, 32'd1000, 32'd3, 32'd333, 32'd1, 0, 0);
        repeat (8) @(negedge clock);
        s32_flush = 1'b1;
        @(negedge clock);
        s32_flush = 1'b0;
        check("flush_busy", busy32, 0);
        check("flush_done", done32, 0);
        void'(sb32.pop_back());
        repeat (40) @(negedge clock);
        check("flush_q_kept", q32, last_q32);
        check("flush_r_kept", r32, last_r32);

        // reset mid operation, with nonzero flags beforehand
        issue32(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0, 1);
        issue32(1, 32'd50, 32'd5, 32'd10, 32'd0, 0, 0);
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_q", q32, 0);
        check("midrst_r", r32, 0);
        check("midrst_busy", busy32, 0);
        check("midrst_flags", {done32, dz32, ov32}, 0);
        sb32.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        issue32(1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, 0);
        wait_idle32();

        for (int i = 0; i < 3000; i++) begin
            rsm = 1'($urandom_range(0, 1));
            ra  = pick();
            rb  = pick();
            model8(rsm, ra, rb, rq, rr, rdz, rov);
            issue8(rsm, ra, rb, rq, rr, rdz, rov);
        end
        wait_idle32();
        wait_idle8();
        repeat (3) @(negedge clock);
        check("sb32_left", sb32.size(), 0);
        check("sb8_left", sb8.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
